// File: rtl/regfile_dbg_pkg.sv
// Shared types and sizes for the register-file debug scan reader.
package regfile_dbg_pkg;

   typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} scan_state_t;

   localparam int REGFILE_NUM_REGS = 32;
   localparam int REGFILE_ADDR_W   = 5;
   localparam int REGFILE_DATA_W   = 32;

endpackage

// File: rtl/regfile_shadow_mem.sv
// Shadow copy of the last emitted register values; one posedge write port, one combinational read port.
module regfile_shadow_mem
   import regfile_dbg_pkg::*;
#(
   parameter int NUM_REGS = REGFILE_NUM_REGS,
   parameter int ADDR_W   = REGFILE_ADDR_W,
   parameter int DATA_W   = REGFILE_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   // No reset: the parent's shadow-valid flag decides whether contents mean anything.
   logic [DATA_W-1:0] r_mem [NUM_REGS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks the register file through read port 3 and streams {addr,data} beats on valid/ready.
//  state | meaning
//  IDLE  | waiting for start; addr parked at 0
//  READ  | sample rd3 for addr, decide emit or skip
//  HOLD  | beat presented, waiting for out_ready
//  DONE  | one-cycle completion pulse, shadow becomes valid
module regfile_scan_reader
   import regfile_dbg_pkg::*;
#(
   parameter int NUM_REGS = REGFILE_NUM_REGS,
   parameter int ADDR_W   = REGFILE_ADDR_W,
   parameter int DATA_W   = REGFILE_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_changed_only,
   output logic [ADDR_W-1:0] o_ra3,
   input  logic [DATA_W-1:0] i_rd3,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ADDR_W-1:0] o_out_addr,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W:0]   o_beat_count
);

   scan_state_t       r_state;
   scan_state_t       w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_mode;
   logic              r_shadow_valid;
   logic              r_out_valid;
   logic [ADDR_W-1:0] r_out_addr;
   logic [DATA_W-1:0] r_out_data;
   logic [ADDR_W:0]   r_beat_count;
   logic [DATA_W-1:0] w_shadow_rdata;
   logic              w_shadow_we;
   logic              w_last;
   logic              w_skip;

   assign w_last = (r_addr == ADDR_W'(NUM_REGS - 1));
   assign w_skip = r_mode & r_shadow_valid & (i_rd3 == w_shadow_rdata);

   regfile_shadow_mem #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W)
   ) u_shadow (
      .i_clk   (i_clk),
      .i_we    (w_shadow_we),
      .i_waddr (r_addr),
      .i_wdata (r_out_data),
      .i_raddr (r_addr),
      .o_rdata (w_shadow_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (i_start) w_next_state = READ;
         READ: begin
            if (!w_skip)     w_next_state = HOLD;
            else if (w_last) w_next_state = DONE;
         end
         HOLD: if (i_out_ready) w_next_state = w_last ? DONE : READ;
         DONE: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (r_state != IDLE);
      o_done      = (r_state == DONE);
      w_shadow_we = (r_state == HOLD) & i_out_ready;
   end

   // Datapath: address walk, captured beat, counters and shadow validity.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_addr         <= '0;
         r_mode         <= 1'b0;
         r_shadow_valid <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_addr     <= '0;
         r_out_data     <= '0;
         r_beat_count   <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_start) begin
               r_addr       <= '0;
               r_beat_count <= '0;
               r_mode       <= i_changed_only;
            end
            READ: begin
               if (!w_skip) begin
                  r_out_valid <= 1'b1;
                  r_out_addr  <= r_addr;
                  r_out_data  <= i_rd3;
               end else if (!w_last) begin
                  r_addr <= r_addr + ADDR_W'(1);
               end
            end
            HOLD: if (i_out_ready) begin
               r_out_valid  <= 1'b0;
               r_beat_count <= r_beat_count + (ADDR_W+1)'(1);
               if (!w_last) r_addr <= r_addr + ADDR_W'(1);
            end
            DONE: begin
               r_shadow_valid <= 1'b1;
               r_addr         <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_ra3        = r_addr;
   assign o_out_valid  = r_out_valid;
   assign o_out_addr   = r_out_addr;
   assign o_out_data   = r_out_data;
   assign o_beat_count = r_beat_count;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Randomized bench for regfile_scan_reader against a queue-based scan model.
module tb_regfile_scan_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        changed_only;
   logic        out_ready;
   logic [4:0]  ra3;
   logic [31:0] rd3;
   logic        out_valid;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        busy;
   logic        done;
   logic [5:0]  beat_count;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } beat_t;

   logic [31:0] rf [32];
   logic [31:0] sh [32];
   bit          sh_valid;
   beat_t       exp_q [$];
   int          n_checks;
   int          n_errors;

   always #5 clk = ~clk;

   assign rd3 = (ra3 == 5'd0) ? 32'h0 : rf[ra3];

   regfile_scan_reader dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_start        (start),
      .i_changed_only (changed_only),
      .o_ra3          (ra3),
      .i_rd3          (rd3),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_out_addr     (out_addr),
      .o_out_data     (out_data),
      .o_busy         (busy),
      .o_done         (done),
      .o_beat_count   (beat_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_scan(input bit mode, input bit rand_ready, input int abort_addr,
                           input bit poke_r3, input bit mid_start);
      int          emitted = 0;
      int          skipped = 0;
      int          stalls = 0;
      int          n = 0;
      int          first_valid = -1;
      bit          got_done = 0;
      bit          aborted = 0;
      bit          stalled = 0;
      logic [4:0]  pa = '0;
      logic [31:0] pd = '0;
      logic [31:0] v;
      beat_t       b;
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
         v = (i == 0) ? 32'h0 : rf[i];
         if (mode && sh_valid && v == sh[i]) skipped++;
         else begin
            b.a = 5'(i);
            b.d = v;
            exp_q.push_back(b);
            emitted++;
         end
      end
      @(negedge clk);
      start = 1'b1;
      changed_only = mode;
      out_ready = 1'b1;
      @(negedge clk);
      while (!got_done && !aborted && n < 3000) begin
         start = mid_start && (n == 20);
         check("busy", busy, 1);
         if (done) got_done = 1;
         else begin
            if (stalled) begin
               check("stall_valid", out_valid, 1);
               check("stall_addr", out_addr, pa);
               check("stall_data", out_data, pd);
            end
            if (out_valid && first_valid < 0) first_valid = n;
            if (out_valid && abort_addr >= 0 && int'(out_addr) == abort_addr) begin
               rst = 1'b0;
               out_ready = 1'b0;
               aborted = 1;
            end else begin
               if (poke_r3 && out_valid && out_addr == 5'd3) rf[3] = 32'hCAFE_0003;
               out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
               if (out_valid) begin
                  check("ra3_tracks_addr", ra3, out_addr);
                  if (out_ready) begin
                     stalled = 0;
                     if (exp_q.size() == 0) check("extra_beat", 1, 0);
                     else begin
                        b = exp_q.pop_front();
                        check("beat_addr", out_addr, b.a);
                        check("beat_data", out_data, b.d);
                        sh[b.a] = b.d;
                     end
                  end else begin
                     stalled = 1;
                     stalls++;
                     pa = out_addr;
                     pd = out_data;
                  end
               end else stalled = 0;
            end
         end
         if (!got_done && !aborted) begin
            @(negedge clk);
            n++;
         end
      end
      start = 1'b0;
      if (aborted) begin
         @(negedge clk);
         check("abort_valid", out_valid, 0);
         check("abort_busy", busy, 0);
         check("abort_done", done, 0);
         check("abort_beats", beat_count, 0);
         rst = 1'b1;
         sh_valid = 0;
         out_ready = 1'b1;
         @(negedge clk);
         check("abort_no_done", done, 0);
         return;
      end
      if (!got_done) begin
         check("done_timeout", 0, 1);
         return;
      end
      check("missing_beats", exp_q.size(), 0);
      check("beat_count", beat_count, emitted);
      check("done_latency", n, 2 * emitted + skipped + stalls);
      if (!mode) check("first_valid", first_valid, 1);
      sh_valid = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("done_single", done, 0);
         check("idle_busy", busy, 0);
         check("idle_ra3", ra3, 0);
         check("beat_count_hold", beat_count, emitted);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      sh_valid = 0;
      rst = 1'b0;
      start = 1'b0;
      changed_only = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'(i * 4 + 1);
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_beats", beat_count, 0);
      check("rst_addr", out_addr, 0);
      check("rst_data", out_data, 0);
      check("rst_ra3", ra3, 0);
      rst = 1'b1;
      @(negedge clk);

      run_scan(1, 0, -1, 0, 0);   // changed-only right after reset: all beats
      run_scan(0, 0, -1, 0, 0);   // plain full scan
      run_scan(0, 1, -1, 0, 0);   // random backpressure
      @(negedge clk);
      rf[7] = 32'hDEAD_BEEF;
      rf[20] = 32'h1;
      run_scan(1, 0, -1, 0, 0);   // only r7 and r20 change
      run_scan(0, 0, 10, 0, 0);   // reset while holding addr 10
      run_scan(1, 0, -1, 0, 0);   // shadow invalid again: all beats
      run_scan(0, 0, -1, 1, 1);   // snapshot + ignored start

      for (int it = 0; it < 4; it++) begin
         @(negedge clk);
         for (int w = 0; w < int'($urandom_range(0, 5)); w++)
            rf[$urandom_range(1, 31)] = $urandom;
         run_scan(1'($urandom_range(0, 1)), 1, -1, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
